// File: rtl/thread_load_receiver_if.sv
// Host-load / datapath-write bundle for thread_load_receiver.
// The slave side is the receiver; the master side is the host plus the
// Datapath instances that consume the write ports and return done flags.
interface thread_load_receiver_if #(
  parameter int NSAT                      = 3,
  parameter int NUM_VARIABLES             = 2048,
  parameter int MAX_CLAUSE_MEMBERSHIP     = 20,
  parameter int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  parameter int NUM_THREADS               = 4
);
  localparam int VAW  = $clog2(NUM_VARIABLES);
  localparam int LAW  = VAW + 1;
  localparam int UAW  = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
  localparam int TW   = $clog2(NUM_THREADS);
  localparam int ATDW = VAW + MAX_CLAUSE_MEMBERSHIP;
  localparam int CTDW = LAW * (NSAT - 1) * MAX_CLAUSE_MEMBERSHIP;
  localparam int UCDW = NSAT * LAW;

  logic                   att_load_valid;
  logic [LAW:0]           att_load_addr;
  logic [ATDW-1:0]        att_load_data;
  logic                   ct_load_valid;
  logic [VAW-1:0]         ct_load_addr;
  logic [CTDW-1:0]        ct_load_data;
  logic                   ucb_load_valid;
  logic [UAW-1:0]         ucb_load_addr;
  logic [UCDW-1:0]        ucb_load_data;
  logic                   load_end;
  logic                   cpu_start;
  logic [NUM_THREADS-1:0] thread_done_i;

  logic [NUM_THREADS-1:0] att_wr_en_o;
  logic [NUM_THREADS-1:0] ct_wr_en_o;
  logic [NUM_THREADS-1:0] ucb_setup_wr_en_o;
  logic [LAW:0]           att_wr_addr_o;
  logic [ATDW-1:0]        att_wr_data_o;
  logic [VAW-1:0]         ct_wr_addr_o;
  logic [CTDW-1:0]        ct_wr_data_o;
  logic [UAW-1:0]         ucb_setup_addr_o;
  logic [UCDW-1:0]        ucb_setup_data_o;
  logic [NUM_THREADS-1:0] ucb_setup_o;
  logic [UAW:0]           ucb_count_o;
  logic [NUM_THREADS-1:0] thread_start_o;
  logic [TW-1:0]          cur_thread_o;
  logic                   cpu_done_o;
  logic                   load_error_o;

  modport slave (
    input  att_load_valid, att_load_addr, att_load_data,
    input  ct_load_valid, ct_load_addr, ct_load_data,
    input  ucb_load_valid, ucb_load_addr, ucb_load_data,
    input  load_end, cpu_start, thread_done_i,
    output att_wr_en_o, ct_wr_en_o, ucb_setup_wr_en_o,
    output att_wr_addr_o, att_wr_data_o, ct_wr_addr_o, ct_wr_data_o,
    output ucb_setup_addr_o, ucb_setup_data_o,
    output ucb_setup_o, ucb_count_o, thread_start_o, cur_thread_o,
    output cpu_done_o, load_error_o
  );

  modport master (
    output att_load_valid, att_load_addr, att_load_data,
    output ct_load_valid, ct_load_addr, ct_load_data,
    output ucb_load_valid, ucb_load_addr, ucb_load_data,
    output load_end, cpu_start, thread_done_i,
    input  att_wr_en_o, ct_wr_en_o, ucb_setup_wr_en_o,
    input  att_wr_addr_o, att_wr_data_o, ct_wr_addr_o, ct_wr_data_o,
    input  ucb_setup_addr_o, ucb_setup_data_o,
    input  ucb_setup_o, ucb_count_o, thread_start_o, cur_thread_o,
    input  cpu_done_o, load_error_o
  );
endinterface

// File: rtl/thread_load_receiver.sv
// Responder for the host load protocol: steers att/ct/ucb beats to the
// thread currently being loaded, closes threads on load_end, broadcasts the
// start pulse once every thread is loaded and gathers per-thread done flags.
module thread_load_receiver #(
  parameter int UNSAT_CLAUSE_BUFFER_DEPTH = 2048,
  parameter int NUM_THREADS               = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  thread_load_receiver_if.slave     bus
);
  localparam int UAW = $clog2(UNSAT_CLAUSE_BUFFER_DEPTH);
  localparam int TW  = $clog2(NUM_THREADS);

  typedef enum logic [1:0] {S_LOAD, S_READY, S_RUN, S_DONE} state_t;

  state_t                 r_state;
  state_t                 w_stateNext;
  logic [TW-1:0]          r_curThread;
  logic [UAW:0]           r_ucbAcc;
  logic [NUM_THREADS-1:0] r_doneMask;

  logic                   w_inLoad;
  logic                   w_lastThread;
  logic                   w_closeThread;
  logic [NUM_THREADS-1:0] w_threadOneHot;
  logic [NUM_THREADS-1:0] w_doneMerged;
  logic [UAW:0]           w_ucbCand;
  logic [UAW:0]           w_ucbAccNext;
  logic [NUM_THREADS-1:0] w_attWrEn;
  logic [NUM_THREADS-1:0] w_ctWrEn;
  logic [NUM_THREADS-1:0] w_ucbWrEn;
  logic [NUM_THREADS-1:0] w_ucbSetup;
  logic [NUM_THREADS-1:0] w_threadStart;
  logic                   w_errorEvent;

  assign w_inLoad       = (r_state == S_LOAD);
  assign w_lastThread   = (r_curThread == TW'(NUM_THREADS - 1));
  assign w_closeThread  = w_inLoad && bus.load_end;
  assign w_threadOneHot = NUM_THREADS'(1) << r_curThread;
  assign w_doneMerged   = r_doneMask | bus.thread_done_i;
  // Widened by one bit so the deepest UCB address yields the full depth.
  assign w_ucbCand      = {1'b0, bus.ucb_load_addr} + (UAW + 1)'(1);

  assign bus.cur_thread_o = r_curThread;
  assign bus.cpu_done_o   = (r_state == S_DONE);

  // State register; DONE is only left through reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_LOAD;
    else     r_state <= w_stateNext;
  end

  // Next-state: close the last thread, wait for start, wait for all done.
  always_comb begin
    w_stateNext = r_state;
    case (r_state)
      S_LOAD:  if (bus.load_end && w_lastThread) w_stateNext = S_READY;
      S_READY: if (bus.cpu_start) w_stateNext = S_RUN;
      S_RUN:   if (&w_doneMerged) w_stateNext = S_DONE;
      default: w_stateNext = r_state;
    endcase
  end

  // Output decode: next-cycle enables, accumulator update and error events.
  always_comb begin
    w_attWrEn     = '0;
    w_ctWrEn      = '0;
    w_ucbWrEn     = '0;
    w_ucbSetup    = '0;
    w_ucbAccNext  = r_ucbAcc;
    if (w_inLoad) begin
      if (bus.att_load_valid) w_attWrEn = w_threadOneHot;
      if (bus.ct_load_valid)  w_ctWrEn  = w_threadOneHot;
      if (bus.ucb_load_valid) begin
        w_ucbWrEn = w_threadOneHot;
        if (w_ucbCand > r_ucbAcc) w_ucbAccNext = w_ucbCand;
      end
      if (bus.load_end) w_ucbSetup = w_threadOneHot;
    end
    w_threadStart = (r_state == S_READY && bus.cpu_start) ? '1 : '0;
    w_errorEvent  = (!w_inLoad && (bus.att_load_valid || bus.ct_load_valid ||
                                   bus.ucb_load_valid || bus.load_end)) ||
                    (w_inLoad && bus.cpu_start);
  end

  // Registered pulses, thread bookkeeping, done mask and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.att_wr_en_o       <= '0;
      bus.ct_wr_en_o        <= '0;
      bus.ucb_setup_wr_en_o <= '0;
      bus.ucb_setup_o       <= '0;
      bus.ucb_count_o       <= '0;
      bus.thread_start_o    <= '0;
      bus.load_error_o      <= 1'b0;
      r_curThread           <= '0;
      r_ucbAcc              <= '0;
      r_doneMask            <= '0;
    end else begin
      bus.att_wr_en_o       <= w_attWrEn;
      bus.ct_wr_en_o        <= w_ctWrEn;
      bus.ucb_setup_wr_en_o <= w_ucbWrEn;
      bus.ucb_setup_o       <= w_ucbSetup;
      bus.thread_start_o    <= w_threadStart;
      bus.ucb_count_o       <= w_closeThread ? w_ucbAccNext : '0;
      if (w_closeThread) begin
        r_ucbAcc <= '0;
        if (!w_lastThread) r_curThread <= r_curThread + TW'(1);
      end else begin
        r_ucbAcc <= w_ucbAccNext;
      end
      if (r_state == S_RUN) r_doneMask <= w_doneMerged;
      if (w_errorEvent) bus.load_error_o <= 1'b1;
    end
  end

  // Shared address/data registers; they only move on an accepted beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.att_wr_addr_o    <= '0;
      bus.att_wr_data_o    <= '0;
      bus.ct_wr_addr_o     <= '0;
      bus.ct_wr_data_o     <= '0;
      bus.ucb_setup_addr_o <= '0;
      bus.ucb_setup_data_o <= '0;
    end else if (w_inLoad) begin
      if (bus.att_load_valid) begin
        bus.att_wr_addr_o <= bus.att_load_addr;
        bus.att_wr_data_o <= bus.att_load_data;
      end
      if (bus.ct_load_valid) begin
        bus.ct_wr_addr_o <= bus.ct_load_addr;
        bus.ct_wr_data_o <= bus.ct_load_data;
      end
      if (bus.ucb_load_valid) begin
        bus.ucb_setup_addr_o <= bus.ucb_load_addr;
        bus.ucb_setup_data_o <= bus.ucb_load_data;
      end
    end
  end
endmodule

// File: tb/tb_thread_load_receiver.sv
// Directed table-driven bench for thread_load_receiver.
module tb_thread_load_receiver;
  typedef struct {
    logic        rst;
    logic        attV;
    logic [12:0] attA;
    logic [30:0] attD;
    logic        ctV;
    logic [10:0] ctA;
    logic [31:0] ctD;
    logic        ucbV;
    logic [10:0] ucbA;
    logic [35:0] ucbD;
    logic        loadEnd;
    logic        cpuStart;
    logic [3:0]  done;
    logic [3:0]  eAtt;
    logic [3:0]  eCt;
    logic [3:0]  eUcb;
    logic [3:0]  eSetup;
    logic [3:0]  eStart;
    logic [11:0] eCount;
    logic [1:0]  eCur;
    logic        eCpuDone;
    logic        eErr;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   failures = 0;
  int   rowIdx = 0;
  vec_t tbl[$];

  thread_load_receiver_if bus ();

  thread_load_receiver dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running 10 ns clock.
  always #5 clk = ~clk;

  // Idle row carrying only the expected persistent status after the edge.
  function automatic vec_t nop(input int cur, input logic err, input logic cpuDone);
    vec_t v;
    v.rst = 1'b0;
    v.attV = 1'b0; v.attA = '0; v.attD = '0;
    v.ctV = 1'b0;  v.ctA = '0;  v.ctD = '0;
    v.ucbV = 1'b0; v.ucbA = '0; v.ucbD = '0;
    v.loadEnd = 1'b0; v.cpuStart = 1'b0; v.done = '0;
    v.eAtt = '0; v.eCt = '0; v.eUcb = '0; v.eSetup = '0; v.eStart = '0;
    v.eCount = '0; v.eCur = 2'(cur); v.eCpuDone = cpuDone; v.eErr = err;
    return v;
  endfunction

  function automatic vec_t resetRow();
    vec_t v;
    v = nop(0, 1'b0, 1'b0);
    v.rst = 1'b1;
    return v;
  endfunction

  function automatic vec_t ctBeat(input int addr, input int cur, input logic err);
    vec_t v;
    v = nop(cur, err, 1'b0);
    v.ctV = 1'b1;
    v.ctA = 11'(addr);
    v.ctD = 32'(32'hA + addr);
    v.eCt = 4'(1 << cur);
    return v;
  endfunction

  function automatic vec_t endRow(input int thr, input int count);
    vec_t v;
    v = nop((thr == 3) ? 3 : thr + 1, 1'b0, 1'b0);
    v.loadEnd = 1'b1;
    v.eSetup = 4'(1 << thr);
    v.eCount = 12'(count);
    return v;
  endfunction

  task automatic cmpVal(input string nm, input logic [479:0] got, input logic [479:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s row %0d: got %0h want %0h", nm, rowIdx, got, want);
    end
  endtask

  task automatic checkOutput(input vec_t v);
    cmpVal("att_wr_en", 480'(bus.att_wr_en_o), 480'(v.eAtt));
    cmpVal("ct_wr_en", 480'(bus.ct_wr_en_o), 480'(v.eCt));
    cmpVal("ucb_wr_en", 480'(bus.ucb_setup_wr_en_o), 480'(v.eUcb));
    cmpVal("ucb_setup", 480'(bus.ucb_setup_o), 480'(v.eSetup));
    cmpVal("ucb_count", 480'(bus.ucb_count_o), 480'(v.eCount));
    cmpVal("thread_start", 480'(bus.thread_start_o), 480'(v.eStart));
    cmpVal("cur_thread", 480'(bus.cur_thread_o), 480'(v.eCur));
    cmpVal("cpu_done", 480'(bus.cpu_done_o), 480'(v.eCpuDone));
    cmpVal("load_error", 480'(bus.load_error_o), 480'(v.eErr));
    if (v.eAtt != 4'd0) begin
      cmpVal("att_addr", 480'(bus.att_wr_addr_o), 480'(v.attA));
      cmpVal("att_data", 480'(bus.att_wr_data_o), 480'(v.attD));
    end
    if (v.eCt != 4'd0) begin
      cmpVal("ct_addr", 480'(bus.ct_wr_addr_o), 480'(v.ctA));
      cmpVal("ct_data", 480'(bus.ct_wr_data_o), 480'(v.ctD));
    end
    if (v.eUcb != 4'd0) begin
      cmpVal("ucb_addr", 480'(bus.ucb_setup_addr_o), 480'(v.ucbA));
      cmpVal("ucb_data", 480'(bus.ucb_setup_data_o), 480'(v.ucbD));
    end
  endtask

  // Drive one row just after a falling edge, check just after the next one.
  task automatic applyStimulus(input vec_t v);
    rst                = v.rst;
    bus.att_load_valid = v.attV;
    bus.att_load_addr  = v.attA;
    bus.att_load_data  = v.attD;
    bus.ct_load_valid  = v.ctV;
    bus.ct_load_addr   = v.ctA;
    bus.ct_load_data   = 480'(v.ctD);
    bus.ucb_load_valid = v.ucbV;
    bus.ucb_load_addr  = v.ucbA;
    bus.ucb_load_data  = v.ucbD;
    bus.load_end       = v.loadEnd;
    bus.cpu_start      = v.cpuStart;
    bus.thread_done_i  = v.done;
    @(negedge clk);
    checkOutput(v);
    rowIdx++;
  endtask

  initial begin
    vec_t v;
    rst = 1'b1;
    bus.att_load_valid = 1'b0; bus.att_load_addr = '0; bus.att_load_data = '0;
    bus.ct_load_valid = 1'b0;  bus.ct_load_addr = '0;  bus.ct_load_data = '0;
    bus.ucb_load_valid = 1'b0; bus.ucb_load_addr = '0; bus.ucb_load_data = '0;
    bus.load_end = 1'b0; bus.cpu_start = 1'b0; bus.thread_done_i = '0;

    // Main table: full load of four threads, start, done collection.
    tbl.push_back(resetRow());
    for (int t = 0; t < 4; t++) begin
      for (int b = 0; b < 3; b++) tbl.push_back(ctBeat(b, t, 1'b0));
      if (t == 0) begin
        v = nop(0, 1'b0, 1'b0);
        v.ucbV = 1'b1; v.ucbA = 11'd5; v.ucbD = 36'h123456789; v.eUcb = 4'b0001;
        tbl.push_back(v);
        v = nop(0, 1'b0, 1'b0);
        v.ucbV = 1'b1; v.ucbA = 11'd2; v.ucbD = 36'hABCDEF012; v.eUcb = 4'b0001;
        tbl.push_back(v);
        v = nop(0, 1'b0, 1'b0);
        v.ctA = 11'h7FF; v.ctD = 32'hDEAD;
        tbl.push_back(v);
      end
      if (t == 3) begin
        v = nop(3, 1'b0, 1'b0);
        v.ucbV = 1'b1; v.ucbA = 11'd2047; v.ucbD = 36'hFFFFFFFFF; v.eUcb = 4'b1000;
        tbl.push_back(v);
      end
      if (t == 2) begin
        v = endRow(2, 8);
        v.attV = 1'b1; v.attA = 13'h1ABC; v.attD = 31'h5555AAAA; v.eAtt = 4'b0100;
        v.ctV = 1'b1;  v.ctA = 11'd3;     v.ctD = 32'hD;          v.eCt = 4'b0100;
        v.ucbV = 1'b1; v.ucbA = 11'd7;    v.ucbD = 36'h777;       v.eUcb = 4'b0100;
        tbl.push_back(v);
      end else begin
        tbl.push_back(endRow(t, (t == 0) ? 6 : (t == 3) ? 2048 : 0));
      end
    end
    tbl.push_back(nop(3, 1'b0, 1'b0));
    v = nop(3, 1'b0, 1'b0); v.cpuStart = 1'b1; v.eStart = 4'hF; tbl.push_back(v);
    v = nop(3, 1'b0, 1'b0); v.done = 4'b0001; tbl.push_back(v);
    v = nop(3, 1'b0, 1'b0); v.done = 4'b1000; tbl.push_back(v);
    v = nop(3, 1'b0, 1'b1); v.done = 4'b0110; tbl.push_back(v);
    tbl.push_back(nop(3, 1'b0, 1'b1));
    v = nop(3, 1'b0, 1'b1); v.cpuStart = 1'b1; tbl.push_back(v);

    @(negedge clk);
    foreach (tbl[i]) applyStimulus(tbl[i]);

    // Beat in READY is dropped and flagged; the state still accepts start.
    applyStimulus(resetRow());
    for (int t = 0; t < 4; t++) applyStimulus(endRow(t, 0));
    v = ctBeat(1, 3, 1'b1); v.eCt = 4'b0000; applyStimulus(v);
    applyStimulus(nop(3, 1'b1, 1'b0));
    v = nop(3, 1'b1, 1'b0); v.cpuStart = 1'b1; v.eStart = 4'hF; applyStimulus(v);
    v = nop(3, 1'b1, 1'b1); v.done = 4'hF; applyStimulus(v);

    // cpu_start during LOAD is ignored but flagged; loading continues.
    applyStimulus(resetRow());
    v = nop(0, 1'b1, 1'b0); v.cpuStart = 1'b1; applyStimulus(v);
    applyStimulus(ctBeat(2, 0, 1'b1));

    // load_end on the last thread together with cpu_start still flags it.
    applyStimulus(resetRow());
    for (int t = 0; t < 3; t++) applyStimulus(endRow(t, 0));
    v = endRow(3, 0); v.cpuStart = 1'b1; v.eErr = 1'b1; applyStimulus(v);
    v = nop(3, 1'b1, 1'b0); v.cpuStart = 1'b1; v.eStart = 4'hF; applyStimulus(v);

    // Reset mid-load of thread 1 discards the pending beat and all status.
    applyStimulus(resetRow());
    applyStimulus(endRow(0, 0));
    v = ctBeat(1, 1, 1'b1); v.cpuStart = 1'b1; applyStimulus(v);
    v = ctBeat(2, 0, 1'b0); v.rst = 1'b1; v.eCt = 4'b0000; applyStimulus(v);
    for (int t = 0; t < 4; t++) begin
      applyStimulus(ctBeat(t, t, 1'b0));
      applyStimulus(endRow(t, 0));
    end
    v = nop(3, 1'b0, 1'b0); v.cpuStart = 1'b1; v.eStart = 4'hF; applyStimulus(v);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
